uart_rx_mmio: RTL and testbench

Memory-mapped receive side of the SoC UART peripheral. It buffers bytes delivered by the UART receiver core in a power-of-two FIFO and presents them to the CPU through a small register window on the peripheral bus: data pop, status and control. It raises a level interrupt when data is pending or an overrun has occurred. It mirrors the transmit-side MMIO block: same bus port set, same word-address decoding on `bus_addr[3:2]`.

---
 rtl/uart_rx_mmio_if.sv | 20 ++
 rtl/uart_rx_mmio.sv | 106 ++++++++++
 tb/tb_uart_rx_mmio.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_mmio_if.sv
// Peripheral bus port set shared by the UART MMIO blocks.
// The CPU side drives the request; the peripheral answers with ready and read data.
interface uart_rx_mmio_if;
  logic        bus_valid;
  logic        bus_wen;
  logic [31:0] bus_wdata;
  logic [31:0] bus_addr;
  logic        uart_ready;
  logic [31:0] mmio_rdata;

  modport master (
    output bus_valid, bus_wen, bus_wdata, bus_addr,
    input  uart_ready, mmio_rdata
  );

  modport slave (
    input  bus_valid, bus_wen, bus_wdata, bus_addr,
    output uart_ready, mmio_rdata
  );
endinterface

// File: rtl/uart_rx_mmio.sv
// UART receive-side MMIO block: buffers received bytes in a FIFO and exposes them
// through RXDATA/STATUS/CTRL words, with a level interrupt on pending data or overrun.
module uart_rx_mmio #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_rx_mmio_if.slave    bus,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_frame_err,
  output logic             rx_irq
);

  typedef logic [FIFO_AW-1:0] ptr_t;
  typedef logic [FIFO_AW:0]   cnt_t;

  logic [8:0] mem_q [FIFO_DEPTH];
  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  cnt_t       count_q, count_d;
  logic       ovr_q, ovr_d;
  logic       ferr_s_q, ferr_s_d;
  logic       irq_en_q, irq_en_d;

  logic [1:0] word;
  logic       empty, full;
  logic       ctrl_wr, flush, clr_sticky;
  logic       pop, push, store;
  logic [8:0] head;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.bus_addr[31:4], bus.bus_addr[1:0], bus.bus_wdata[31:3]};

  always_comb begin
    word       = bus.bus_addr[3:2];
    empty      = (count_q == '0);
    full       = (count_q == cnt_t'(FIFO_DEPTH));
    ctrl_wr    = bus.bus_valid && bus.bus_wen && (word == 2'd2);
    flush      = ctrl_wr && bus.bus_wdata[1];
    clr_sticky = ctrl_wr && bus.bus_wdata[2];
    pop        = bus.bus_valid && !bus.bus_wen && (word == 2'd0) && !empty;
    push       = rx_valid && (!full || pop);
    store      = push && !flush;
  end

  // Flush overrides any concurrent push/pop; sticky sets win over clears.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + ptr_t'(store);
      rd_ptr_d = rd_ptr_q + ptr_t'(pop);
      count_d  = count_q + cnt_t'(store) - cnt_t'(pop);
    end

    ovr_d    = clr_sticky ? 1'b0 : ovr_q;
    ferr_s_d = clr_sticky ? 1'b0 : ferr_s_q;
    if (rx_valid && full && !pop && !flush) ovr_d = 1'b1;
    if (rx_valid && rx_frame_err) ferr_s_d = 1'b1;

    irq_en_d = ctrl_wr ? bus.bus_wdata[0] : irq_en_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      ferr_s_q <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      ferr_s_q <= ferr_s_d;
      irq_en_q <= irq_en_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && store) mem_q[wr_ptr_q] <= {rx_frame_err, rx_data};
  end

  always_comb begin
    head = mem_q[rd_ptr_q];
    case (word)
      2'd0:    bus.mmio_rdata = empty ? 32'h8000_0000 : {23'b0, head};
      2'd1:    bus.mmio_rdata = {16'b0, 8'(count_q), 3'b0, irq_en_q, ferr_s_q, ovr_q, full, empty};
      2'd2:    bus.mmio_rdata = {31'b0, irq_en_q};
      default: bus.mmio_rdata = 32'h0;
    endcase
  end

  assign bus.uart_ready = 1'b1;
  assign rx_irq         = irq_en_q && (!empty || ovr_q);

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio: directed scenarios plus random traffic,
// all compared against a queue-based model of the register window.
module tb_uart_rx_mmio;
  localparam int DEPTH = 16;
  localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4, A_CTRL = 32'h8, A_RSVD = 32'hC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_frame_err;
  logic       rx_irq;

  int vectors = 0;
  int miscompares = 0;

  uart_rx_mmio_if bus ();

  uart_rx_mmio #(.FIFO_DEPTH(DEPTH), .FIFO_AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_frame_err(rx_frame_err), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO is a plain queue of {ferr, data} entries.
  logic [8:0] mq[$];
  bit m_ovr, m_ferr, m_irq_en;

  function automatic logic [31:0] model_rdata(input logic [1:0] w);
    logic [31:0] r;
    int n;
    n = mq.size();
    case (w)
      2'd0: r = (n == 0) ? 32'h8000_0000 : {23'b0, mq[0]};
      2'd1: r = (n * 256) + (m_irq_en ? 16 : 0) + (m_ferr ? 8 : 0) + (m_ovr ? 4 : 0)
                + ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0);
      2'd2: r = {31'b0, m_irq_en};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic bit model_irq();
    return m_irq_en && (mq.size() > 0 || m_ovr);
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ovr = 0;
    m_ferr = 0;
    m_irq_en = 0;
  endfunction

  function automatic void model_update(input bit v, input bit w, input logic [31:0] a,
                                       input logic [31:0] d, input bit rv, input logic [7:0] rd,
                                       input bit rf);
    bit is_read, is_ctrl;
    is_read = v && !w && (a[3:2] == 2'd0);
    is_ctrl = v && w && (a[3:2] == 2'd2);
    if (is_ctrl && d[2]) begin
      m_ovr = 0;
      m_ferr = 0;
    end
    if (rv && rf) m_ferr = 1;
    if (is_ctrl && d[1]) begin
      mq.delete();
    end else begin
      if (is_read && mq.size() > 0) void'(mq.pop_front());
      if (rv) begin
        if (mq.size() < DEPTH) mq.push_back({rf, rd});
        else m_ovr = 1;
      end
    end
    if (is_ctrl) m_irq_en = d[0];
  endfunction

  task automatic idle_inputs();
    bus.bus_valid = 0;
    bus.bus_wen = 0;
    bus.bus_wdata = 32'h0;
    rx_valid = 0;
    rx_data = 8'h0;
    rx_frame_err = 0;
  endtask

  // One bus/rx cycle: returns the read data seen before the edge and the model's value.
  task automatic step(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input bit rv, input logic [7:0] rd, input bit rf,
                      output logic [31:0] obs, output logic [31:0] exp);
    bus.bus_valid = v;
    bus.bus_wen = w;
    bus.bus_addr = a;
    bus.bus_wdata = d;
    rx_valid = rv;
    rx_data = rd;
    rx_frame_err = rf;
    #1;
    obs = bus.mmio_rdata;
    exp = model_rdata(a[3:2]);
    model_update(v, w, a, d, rv, rd, rf);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] obs);
    bus.bus_valid = 0;
    bus.bus_addr = a;
    #1;
    obs = bus.mmio_rdata;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    rx_valid = 1;
    rx_data = 8'hEE;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1;
    idle_inputs();
    model_reset();
  endtask

  task automatic fill(input int n, input int base);
    logic [31:0] o, e;
    for (int i = 0; i < n; i++) step(0, 0, A_STAT, 0, 1, 8'(base + i), 0, o, e);
  endtask

  task automatic test_reset();
    logic [31:0] o;
    do_reset();
    peek(A_DATA, o);
    vectors++;
    if (o !== 32'h8000_0000) begin miscompares++; $display("[TB] FAIL reset_rxdata got %h want %h", o, 32'h8000_0000); end
    peek(A_STAT, o);
    vectors++;
    if (o !== 32'h0000_0001) begin miscompares++; $display("[TB] FAIL reset_status got %h want %h", o, 32'h1); end
    vectors++;
    if (rx_irq !== 1'b0 || bus.uart_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_irq_ready got irq=%b ready=%b want irq=0 ready=1", rx_irq, bus.uart_ready);
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] o, e;
    fill(16, 0);
    peek(A_STAT, o);
    vectors++;
    if (o !== 32'h0000_1002) begin miscompares++; $display("[TB] FAIL full_status got %h want %h", o, 32'h1002); end
    for (int i = 0; i < 17; i++) begin
      step(1, 0, A_DATA, 0, 0, 0, 0, o, e);
      vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL drain_%0d got %h want %h", i, o, e); end
    end
    peek(A_STAT, o);
    vectors++;
    if (o !== 32'h0000_0001) begin miscompares++; $display("[TB] FAIL drained_status got %h want %h", o, 32'h1); end
  endtask

  task automatic test_overrun();
    logic [31:0] o, e;
    fill(16, 0);
    step(0, 0, A_STAT, 0, 1, 8'hAA, 0, o, e);
    peek(A_STAT, o);
    vectors++;
    if (o !== 32'h0000_1006) begin miscompares++; $display("[TB] FAIL ovr_status got %h want %h", o, 32'h1006); end
    step(1, 1, A_CTRL, 32'h4, 0, 0, 0, o, e);
    peek(A_STAT, o);
    vectors++;
    if (o !== 32'h0000_1002) begin miscompares++; $display("[TB] FAIL ovr_clear got %h want %h", o, 32'h1002); end
    peek(A_DATA, o);
    vectors++;
    if (o !== 32'h0000_0000) begin miscompares++; $display("[TB] FAIL ovr_head got %h want %h", o, 32'h0); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] o, e;
    step(1, 0, A_DATA, 0, 1, 8'h55, 0, o, e);
    vectors++;
    if (o !== 32'h0) begin miscompares++; $display("[TB] FAIL fullpp_head got %h want %h", o, 32'h0); end
    peek(A_STAT, o);
    vectors++;
    if (o !== 32'h0000_1002) begin miscompares++; $display("[TB] FAIL fullpp_status got %h want %h", o, 32'h1002); end
    for (int i = 0; i < 16; i++) begin
      step(1, 0, A_DATA, 0, 0, 0, 0, o, e);
      vectors++;
      if (o !== ((i < 15) ? 32'(i + 1) : 32'h55)) begin
        miscompares++; $display("[TB] FAIL fullpp_drain_%0d got %h want %h", i, o, (i < 15) ? 32'(i + 1) : 32'h55);
      end
    end
  endtask

  task automatic test_frame_err();
    logic [31:0] o, e;
    step(0, 0, A_STAT, 0, 1, 8'h3C, 1, o, e);
    peek(A_DATA, o);
    vectors++;
    if (o !== 32'h0000_013C) begin miscompares++; $display("[TB] FAIL ferr_data got %h want %h", o, 32'h13C); end
    peek(A_STAT, o);
    vectors++;
    if (o[3] !== 1'b1) begin miscompares++; $display("[TB] FAIL ferr_sticky got %b want 1", o[3]); end
    step(1, 1, A_CTRL, 32'h4, 0, 0, 0, o, e);
    peek(A_STAT, o);
    vectors++;
    if (o[3] !== 1'b0) begin miscompares++; $display("[TB] FAIL ferr_clear got %b want 0", o[3]); end
    step(1, 0, A_DATA, 0, 0, 0, 0, o, e);
  endtask

  task automatic test_irq();
    logic [31:0] o, e;
    step(1, 1, A_CTRL, 32'h1, 0, 0, 0, o, e);
    vectors++;
    if (rx_irq !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_empty got %b want 0", rx_irq); end
    step(0, 0, A_STAT, 0, 1, 8'h11, 0, o, e);
    vectors++;
    if (rx_irq !== 1'b1) begin miscompares++; $display("[TB] FAIL irq_push got %b want 1", rx_irq); end
    step(1, 0, A_DATA, 0, 0, 0, 0, o, e);
    vectors++;
    if (rx_irq !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_pop got %b want 0", rx_irq); end
    fill(17, 8'h20);
    for (int i = 0; i < 16; i++) step(1, 0, A_DATA, 0, 0, 0, 0, o, e);
    step(1, 1, A_CTRL, 32'h3, 0, 0, 0, o, e);
    vectors++;
    if (rx_irq !== 1'b1) begin miscompares++; $display("[TB] FAIL irq_ovr_hold got %b want 1", rx_irq); end
    step(1, 1, A_CTRL, 32'h5, 0, 0, 0, o, e);
    vectors++;
    if (rx_irq !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_ovr_clear got %b want 0", rx_irq); end
  endtask

  task automatic test_flush_race();
    logic [31:0] o, e;
    fill(5, 8'h40);
    step(1, 1, A_CTRL, 32'h2, 1, 8'h99, 0, o, e);
    peek(A_STAT, o);
    vectors++;
    if (o !== 32'h0000_0001) begin miscompares++; $display("[TB] FAIL flush_status got %h want %h", o, 32'h1); end
    peek(A_DATA, o);
    vectors++;
    if (o !== 32'h8000_0000) begin miscompares++; $display("[TB] FAIL flush_rxdata got %h want %h", o, 32'h8000_0000); end
  endtask

  task automatic test_wrap();
    logic [31:0] o, e;
    step(0, 0, A_STAT, 0, 1, 8'h00, 0, o, e);
    for (int i = 1; i <= 40; i++) begin
      step(1, 0, A_DATA, 0, 1, 8'(i), 0, o, e);
      vectors++;
      if (o !== 32'(i - 1)) begin miscompares++; $display("[TB] FAIL wrap_%0d got %h want %h", i, o, 32'(i - 1)); end
    end
    step(1, 0, A_DATA, 0, 0, 0, 0, o, e);
    vectors++;
    if (o !== 32'd40) begin miscompares++; $display("[TB] FAIL wrap_last got %h want %h", o, 32'd40); end
  endtask

  task automatic test_random();
    logic [31:0] o, e, a, d;
    bit v, w, rv;
    for (int i = 0; i < 400; i++) begin
      a = {$urandom_range(0, 255) << 4} | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      v = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 2) == 0);
      d = $urandom & 32'hFFFF_FFF9;
      if ($urandom_range(0, 15) == 0) d[1] = 1'b1;
      if ($urandom_range(0, 5) == 0) d[2] = 1'b1;
      rv = ($urandom_range(0, 1) == 1);
      step(v, w, a, d, rv, 8'($urandom), ($urandom_range(0, 7) == 0), o, e);
      vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL rand_rdata_%0d got %h want %h", i, o, e); end
      vectors++;
      if (rx_irq !== model_irq()) begin miscompares++; $display("[TB] FAIL rand_irq_%0d got %b want %b", i, rx_irq, model_irq()); end
    end
    peek(A_RSVD, o);
    vectors++;
    if (o !== 32'h0) begin miscompares++; $display("[TB] FAIL rsvd_read got %h want %h", o, 32'h0); end
  endtask

  task automatic test_midreset();
    logic [31:0] o;
    fill(3, 8'h70);
    do_reset();
    peek(A_STAT, o);
    vectors++;
    if (o !== 32'h0000_0001) begin miscompares++; $display("[TB] FAIL midreset_status got %h want %h", o, 32'h1); end
  endtask

  initial begin
    bus.bus_addr = 32'h0;
    idle_inputs();
    rst_n = 0;
    #1;
    test_reset();
    test_fill_drain();
    test_overrun();
    test_full_push_pop();
    test_frame_err();
    test_irq();
    test_flush_race();
    test_wrap();
    test_random();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
